// File: rtl/spike_enc_pkg.sv
// Shared types and default configuration for the rate-coding spike encoder.
package spike_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

  localparam int N_CH_DEF    = 3;
  localparam int VAL_W_DEF   = 4;
  localparam int WIN_LEN_DEF = 16;

endpackage

// File: rtl/spike_enc_channel.sv
// One encoder channel: latched intensity, modulo-2^VAL_W phase accumulator, registered spike.
module spike_enc_channel #(
  parameter int VAL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             load,
  input  logic             tick,
  input  logic             clear,
  input  logic [VAL_W-1:0] val,
  output logic             spike
);

  logic [VAL_W-1:0] r_val;
  logic [VAL_W-1:0] r_acc;
  logic             r_spike;
  logic [VAL_W:0]   w_sum;

  // Carry out of the accumulator is the spike.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_val};

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_val   <= '0;
      r_acc   <= '0;
      r_spike <= 1'b0;
    end else begin
      if (load) begin
        r_val <= val;
        r_acc <= '0;
      end else if (tick) begin
        r_acc <= w_sum[VAL_W-1:0];
      end
      if (clear) begin
        r_spike <= 1'b0;
      end else if (tick) begin
        r_spike <= w_sum[VAL_W];
      end
    end
  end

  assign spike = r_spike;

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding spike source: FSM, tick counter and load handshake over N_CH channels.
// Optional abort input enabled by defining SPIKE_ENC_ABORT_EN.
module spike_encoder
  import spike_enc_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int VAL_W   = VAL_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  load_valid_i,
`ifdef SPIKE_ENC_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic                  load_ready_o,
  input  logic [N_CH*VAL_W-1:0] val_i,
  output logic [N_CH-1:0]       s_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int TW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(WIN_LEN - 1);

  enc_state_t    r_state;
  enc_state_t    w_next;
  logic [TW-1:0] r_cnt;
  logic          w_load;
  logic          w_tick;
  logic          w_clear;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_tick  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_valid_i) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        w_tick = 1'b1;
        if (r_cnt == LAST_TICK) w_next = DONE;
      end
      DONE: begin
        w_next  = IDLE;
        w_clear = 1'b1;
      end
      default: begin
        w_next  = IDLE;
        w_clear = 1'b1;
      end
    endcase
`ifdef SPIKE_ENC_ABORT_EN
    // Abort overrides both the tick and the DONE exit on the same edge.
    if (abort_i && (r_state != IDLE)) begin
      w_next  = IDLE;
      w_tick  = 1'b0;
      w_clear = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_tick && (r_cnt != LAST_TICK)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    spike_enc_channel #(
      .VAL_W(VAL_W)
    ) u_ch (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .load  (w_load),
      .tick  (w_tick),
      .clear (w_clear),
      .val   (val_i[c*VAL_W +: VAL_W]),
      .spike (s_o[c])
    );
  end

  assign load_ready_o = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);

endmodule
